horner_sequencer: RTL and testbench

Host-side sequencer for the Horner polynomial datapath. It accepts samples from upstream over a valid/ready handshake, holds each sample stable to the datapath, and issues a one-cycle srdyi start pulse. It then waits for the datapath's srdyo, captures the result into a 2-entry output FIFO, and presents results downstream over valid/ready. It also flags latency mismatches and timeouts.

---
 rtl/horner_sequencer.sv | 145 ++++++++++++++
 tb/tb_horner_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/horner_sequencer.sv
// Host-side sequencer for the Horner datapath: accepts a sample, launches the datapath,
// waits for its result with latency/timeout checking, and buffers results in a 2-entry FIFO.
module horner_sequencer #(
    parameter int         DATA_W  = 20,
    parameter int         RES_W   = 20,
    parameter logic [7:0] LATENCY = 8'd197,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic              clk,
    input  logic              GlobalReset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] x_out,
    output logic              srdyi,
    input  logic              srdyo,
    input  logic [RES_W-1:0]  y_in,
    output logic              out_valid,
    output logic [RES_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              lat_err,
    output logic              timeout_err,
    input  logic              err_clr,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends combinationally on ready.
    state_t              state_q, state_d;
    logic [DATA_W-1:0]   x_out_q, x_out_d;
    logic                srdyi_q, srdyi_d;
    logic [7:0]          wait_cnt_q, wait_cnt_d;
    logic [RES_W-1:0]    mem_q [2];
    logic [RES_W-1:0]    mem_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          fifo_count_q, fifo_count_d;
    logic                lat_err_q, lat_err_d;
    logic                timeout_err_q, timeout_err_d;

    logic accept, push, pop, lat_set, to_set;

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LAUNCH;
            LAUNCH:  state_d = WAIT;
            WAIT:    if (srdyo || (wait_cnt_q == TIMEOUT)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && (fifo_count_q != 2'd2);
        busy      = (state_q != IDLE);
        state_dbg = state_q;
    end

    always_comb begin
        accept  = in_valid && in_ready;
        push    = (state_q == WAIT) && srdyo;
        pop     = out_valid && out_ready;
        // srdyo outside WAIT is always a latency fault; inside WAIT only the exact count is legal.
        lat_set = srdyo && ((state_q != WAIT) || (wait_cnt_q != LATENCY));
        to_set  = (state_q == WAIT) && !srdyo && (wait_cnt_q == TIMEOUT);

        x_out_d = accept ? in_data : x_out_q;
        srdyi_d = accept;

        wait_cnt_d = wait_cnt_q;
        if (state_q == LAUNCH) begin
            wait_cnt_d = 8'd1;
        end else if ((state_q == WAIT) && (wait_cnt_q != TIMEOUT)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = y_in;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + 2'd1;
            2'b01:   fifo_count_d = fifo_count_q - 2'd1;
            default: fifo_count_d = fifo_count_q;
        endcase

        lat_err_d     = lat_set ? 1'b1 : (err_clr ? 1'b0 : lat_err_q);
        timeout_err_d = to_set  ? 1'b1 : (err_clr ? 1'b0 : timeout_err_q);
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            x_out_q       <= '0;
            srdyi_q       <= 1'b0;
            wait_cnt_q    <= 8'd0;
            mem_q[0]      <= '0;
            mem_q[1]      <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_count_q  <= 2'd0;
            lat_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            x_out_q       <= x_out_d;
            srdyi_q       <= srdyi_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_q[0]      <= mem_d[0];
            mem_q[1]      <= mem_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_count_q  <= fifo_count_d;
            lat_err_q     <= lat_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign x_out       = x_out_q;
    assign srdyi       = srdyi_q;
    assign out_valid   = (fifo_count_q != 2'd0);
    assign out_data    = mem_q[rd_ptr_q];
    assign lat_err     = lat_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_horner_sequencer.sv
// Self-checking bench for horner_sequencer: a behavioural datapath responder with chosen
// response delays, a result scoreboard popped by an independent output monitor.
module tb_horner_sequencer;
  localparam int DW  = 20;
  localparam int RW  = 20;
  localparam int LAT = 197;
  localparam int TMO = 255;

  logic          clk = 1'b0;
  logic          GlobalReset = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          srdyo = 1'b0;
  logic [RW-1:0] y_in = '0;
  logic          out_ready = 1'b0;
  logic          err_clr = 1'b0;
  logic          in_ready, srdyi, out_valid, busy, lat_err, timeout_err;
  logic [DW-1:0] x_out;
  logic [RW-1:0] out_data;
  logic [1:0]    state_dbg;

  int            pass_cnt = 0;
  int            total_cnt = 0;
  logic [RW-1:0] exp_q[$];
  bit            exp_lat = 1'b0;
  bit            exp_to = 1'b0;
  bit            ready_mode = 1'b0;
  bit            ready_force = 1'b0;

  horner_sequencer dut (
    .clk(clk), .GlobalReset(GlobalReset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .x_out(x_out), .srdyi(srdyi), .srdyo(srdyo), .y_in(y_in),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .lat_err(lat_err), .timeout_err(timeout_err),
    .err_clr(err_clr), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // downstream ready driver, settles 1ns after the falling edge
  initial begin
    forever begin
      @(negedge clk);
      #1;
      out_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (GlobalReset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_output: got %0h expected none", out_data);
        end else begin
          chk("fifo_order", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // One transaction: dly in 1..TMO gives srdyo at L+dly, larger gives no response.
  task automatic run_txn(input logic [DW-1:0] d, input int dly, input logic [RW-1:0] y,
                         input bit pop_at, input bit clr_at);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("srdyi_launch", 32'(srdyi), 32'd1);
    chk("x_out_launch", 32'(x_out), 32'(d));
    @(negedge clk);
    chk("srdyi_one_cycle", 32'(srdyi), 32'd0);
    if (dly <= TMO) begin
      repeat (dly - 1) @(negedge clk);
      srdyo = 1'b1;
      y_in  = y;
      exp_q.push_back(y);
      if (pop_at) ready_force = 1'b1;
      if (clr_at) begin
        err_clr = 1'b1;
        exp_lat = 1'b0;
        exp_to  = 1'b0;
      end
      if (dly != LAT) exp_lat = 1'b1;
      @(negedge clk);
      srdyo   = 1'b0;
      err_clr = 1'b0;
      if (pop_at) ready_force = 1'b0;
      chk("x_out_held", 32'(x_out), 32'(d));
    end else begin
      repeat (TMO - 1) @(negedge clk);
      @(negedge clk);
      exp_to = 1'b1;
      chk("in_ready_after_timeout", 32'(in_ready), 32'(exp_q.size() < 2));
    end
    chk("busy_done", 32'(busy), 32'd0);
    chk("lat_err", 32'(lat_err), 32'(exp_lat));
    chk("timeout_err", 32'(timeout_err), 32'(exp_to));
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_force = 1'b1;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ready_force = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("out_valid_empty", 32'(out_valid), 32'd0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_lat = 1'b0;
    exp_to  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_x_out", 32'(x_out), 32'd0);
    chk("rst_srdyi", 32'(srdyi), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_flags", {30'd0, lat_err, timeout_err}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    GlobalReset = 1'b1;
    @(negedge clk);

    // nominal transaction
    run_txn(20'h12345, LAT, 20'hABCDE, 1'b0, 1'b0);
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_data", 32'(out_data), 32'hABCDE);
    drain();

    // fill the FIFO, third sample blocked until a pop
    run_txn(20'h00011, LAT, 20'h0A001, 1'b0, 1'b0);
    run_txn(20'h00022, LAT, 20'h0A002, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 20'h00033;
    repeat (4) @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd0);
    chk("full_no_launch", 32'(srdyi), 32'd0);
    ready_force = 1'b1;
    @(negedge clk);
    ready_force = 1'b0;
    run_txn(20'h00033, LAT, 20'h0A003, 1'b0, 1'b0);
    drain();

    // latency errors and sticky clear priority
    ready_mode = 1'b1;
    run_txn(20'h00101, 190, 20'h0B001, 1'b0, 1'b0);
    run_txn(20'h00102, LAT, 20'h0B002, 1'b0, 1'b0);
    run_txn(20'h00103, 180, 20'h0B003, 1'b0, 1'b1);
    pulse_clr();
    chk("lat_cleared", 32'(lat_err), 32'd0);
    ready_mode = 1'b0;
    drain();

    // timeout, then srdyo exactly on the timeout cycle
    run_txn(20'h00201, 300, 20'h0, 1'b0, 1'b0);
    chk("timeout_fifo_unchanged", 32'(out_valid), 32'd0);
    pulse_clr();
    run_txn(20'h00202, TMO, 20'h0C002, 1'b0, 1'b0);
    chk("edge_timeout_clear", 32'(timeout_err), 32'd0);
    drain();
    pulse_clr();

    // push and pop together at count 1, then a stray srdyo in IDLE
    run_txn(20'h00301, LAT, 20'h0D001, 1'b0, 1'b0);
    run_txn(20'h00302, LAT, 20'h0D002, 1'b1, 1'b0);
    chk("pushpop_valid", 32'(out_valid), 32'd1);
    chk("pushpop_data", 32'(out_data), 32'h0D002);
    srdyo = 1'b1;
    y_in  = 20'h0EEEE;
    @(negedge clk);
    srdyo   = 1'b0;
    exp_lat = 1'b1;
    @(negedge clk);
    chk("stray_lat_err", 32'(lat_err), 32'd1);
    chk("stray_no_push", 32'(out_data), 32'h0D002);
    drain();

    // asynchronous reset mid-WAIT with a result and an error pending
    run_txn(20'h00401, LAT, 20'h0F001, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 20'h00402;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_wait_busy", 32'(busy), 32'd1);
    #1;
    GlobalReset = 1'b0;
    #1;
    chk("arst_x_out", 32'(x_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_flags", {30'd0, lat_err, timeout_err}, 32'd0);
    exp_q.delete();
    exp_lat = 1'b0;
    exp_to  = 1'b0;
    @(negedge clk);
    GlobalReset = 1'b1;
    @(negedge clk);
    srdyo = 1'b1;
    @(negedge clk);
    srdyo   = 1'b0;
    exp_lat = 1'b1;
    @(negedge clk);
    chk("post_rst_stray", 32'(lat_err), 32'd1);
    chk("post_rst_no_push", 32'(out_valid), 32'd0);
    pulse_clr();
    run_txn(20'h00403, LAT, 20'h0F003, 1'b0, 1'b0);
    drain();

    // randomized traffic
    ready_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int dly;
      case ($urandom_range(0, 3))
        0, 1:    dly = LAT;
        2:       dly = int'($urandom_range(1, TMO));
        default: dly = 300;
      endcase
      run_txn(DW'($urandom), dly, RW'($urandom), 1'b0, 1'($urandom_range(0, 1)));
    end
    ready_mode = 1'b0;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // global watchdog
  initial begin
    #800000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end
endmodule
